// File: rtl/usb11_pkg.sv
// Shared constants for the low-speed USB receive path: line states,
// receiver FSM encoding, oversampling ratio, stuffing limit and PIDs.
package usb11_pkg;

    // Low-speed line states as {dp, dm}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // 12 MHz system clock over 1.5 Mbit/s line rate
    localparam int unsigned OVERSAMPLE = 8;

    // After this many consecutive ones the next bit is a stuffed zero
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP      = 3'd3,
        ST_ERR_WAIT = 3'd4
    } rx_state_t;

    // PID bytes as they appear on the wire ({~pid, pid})
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

endpackage

// File: rtl/usb11_recv_if.sv
// Byte/packet strobe bundle between the USB receiver and the packet layer.
interface usb11_recv_if;
    logic [7:0] rbyte;
    logic       rbyte_wr;
    logic       pkt_start;
    logic       pkt_end;
    logic       pkt_err;
    logic       rx_active;

    // Receiver side drives the strobes
    modport master (output rbyte, rbyte_wr, pkt_start, pkt_end, pkt_err, rx_active);
    // Packet layer consumes them
    modport slave  (input  rbyte, rbyte_wr, pkt_start, pkt_end, pkt_err, rx_active);
endinterface

// File: rtl/usb11_rx_dpll.sv
// Line synchronizer and bit-timing recovery: one sample strobe per bit,
// re-aligned to mid-bit on every observed transition.
module usb11_rx_dpll
    import usb11_pkg::*;
#(
    parameter int unsigned SAMPLE_PHASE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    output logic [1:0] line_state,
    output logic       sample_en,
    output logic [1:0] level
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] SAMPLE_AT = PH_W'(SAMPLE_PHASE);

    logic [1:0]      line_raw;
    logic [1:0]      sync_line;
    logic [1:0]      prev_reg;
    logic [PH_W-1:0] phase_reg;
    logic            edge_seen;

    assign line_raw = {dp, dm};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            localparam logic RST_VAL = LS_J[gi];
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchronizer per bus line, idling at J
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= RST_VAL;
                    sync_reg <= RST_VAL;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_line[gi] = sync_reg;
        end
    endgenerate

    assign edge_seen = (sync_line != prev_reg);

    // Previous-level register and phase counter cleared on each transition
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= LS_J;
            phase_reg <= '0;
        end else begin
            prev_reg  <= sync_line;
            phase_reg <= edge_seen ? '0 : phase_reg + 1'b1;
        end
    end

    // No sample on the transition clock itself, so a stale phase can never
    // sample a freshly started bit twice.
    assign sample_en  = !edge_seen && (phase_reg == SAMPLE_AT);
    assign level      = sync_line;
    assign line_state = sync_line;

endmodule

// File: rtl/usb11_recv.sv
// Low-speed USB receiver: SYNC detection, NRZI decode, bit unstuffing,
// LSB-first byte assembly and EOP / error framing toward the packet layer.
module usb11_recv
    import usb11_pkg::*;
#(
    parameter int unsigned SAMPLE_PHASE   = 4,
    parameter int unsigned SYNC_MIN_ZEROS = 5,
    parameter int unsigned MAX_BYTES      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dp,
    input  logic          dm,
    input  logic          bus_enable,
    output logic [1:0]    line_state,
    usb11_recv_if.master  pkt
);
    localparam logic [3:0] SYNC_MIN  = 4'(SYNC_MIN_ZEROS);
    localparam logic [7:0] BYTE_LIMIT = 8'(MAX_BYTES);

    logic       sample_en;
    logic [1:0] level;
    logic       bit_val;

    rx_state_t  state_reg, state_next;
    logic [3:0] zero_cnt_reg, zero_cnt_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0] ones_cnt_reg, ones_cnt_next;
    logic [7:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [1:0] last_level_reg, last_level_next;
    logic [1:0] se0_cnt_reg, se0_cnt_next;
    logic       j_cnt_reg, j_cnt_next;

    logic       sync_ok, byte_done, end_ok, end_bad, abort;

    logic [7:0] rbyte_reg, rbyte_next;
    logic       rbyte_wr_reg, rbyte_wr_next;
    logic       pkt_start_reg, pkt_start_next;
    logic       pkt_end_reg, pkt_end_next;
    logic       pkt_err_reg, pkt_err_next;

    usb11_rx_dpll #(.SAMPLE_PHASE(SAMPLE_PHASE)) u_dpll (
        .clk        (clk),
        .rst        (rst),
        .dp         (dp),
        .dm         (dm),
        .line_state (line_state),
        .sample_en  (sample_en),
        .level      (level)
    );

    // NRZI: no level change means a one
    assign bit_val = (level == last_level_reg);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            zero_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            ones_cnt_reg   <= '0;
            byte_cnt_reg   <= '0;
            shreg_reg      <= '0;
            last_level_reg <= LS_J;
            se0_cnt_reg    <= '0;
            j_cnt_reg      <= 1'b0;
            rbyte_reg      <= '0;
            rbyte_wr_reg   <= 1'b0;
            pkt_start_reg  <= 1'b0;
            pkt_end_reg    <= 1'b0;
            pkt_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            zero_cnt_reg   <= zero_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            ones_cnt_reg   <= ones_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            shreg_reg      <= shreg_next;
            last_level_reg <= last_level_next;
            se0_cnt_reg    <= se0_cnt_next;
            j_cnt_reg      <= j_cnt_next;
            rbyte_reg      <= rbyte_next;
            rbyte_wr_reg   <= rbyte_wr_next;
            pkt_start_reg  <= pkt_start_next;
            pkt_end_reg    <= pkt_end_next;
            pkt_err_reg    <= pkt_err_next;
        end
    end

    // Next-state and datapath update, evaluated once per bit sample
    always_comb begin
        state_next      = state_reg;
        zero_cnt_next   = zero_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        ones_cnt_next   = ones_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        shreg_next      = shreg_reg;
        last_level_next = last_level_reg;
        se0_cnt_next    = se0_cnt_reg;
        j_cnt_next      = j_cnt_reg;
        sync_ok         = 1'b0;
        byte_done       = 1'b0;
        end_ok          = 1'b0;
        end_bad         = 1'b0;
        abort           = 1'b0;
        if (bus_enable) begin
            // Our own transmitter owns the bus; anything in flight is lost
            state_next      = ST_IDLE;
            last_level_next = LS_J;
            abort           = (state_reg == ST_DATA) || (state_reg == ST_EOP);
        end else if (sample_en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (level == LS_K) begin
                        state_next      = ST_SYNC;
                        zero_cnt_next   = 4'd1;
                        last_level_next = LS_K;
                    end
                end
                ST_SYNC: begin
                    if (level == LS_J || level == LS_K) begin
                        last_level_next = level;
                        if (!bit_val) begin
                            if (zero_cnt_reg != 4'hF)
                                zero_cnt_next = zero_cnt_reg + 1'b1;
                        end else if (zero_cnt_reg >= SYNC_MIN) begin
                            state_next    = ST_DATA;
                            sync_ok       = 1'b1;
                            bit_cnt_next  = '0;
                            ones_cnt_next = '0;
                            byte_cnt_next = '0;
                        end else begin
                            state_next      = ST_IDLE;
                            last_level_next = LS_J;
                        end
                    end else begin
                        state_next      = ST_IDLE;
                        last_level_next = LS_J;
                    end
                end
                ST_DATA: begin
                    if (level == LS_SE0) begin
                        state_next   = ST_EOP;
                        se0_cnt_next = 2'd1;
                    end else if (level == LS_SE1) begin
                        end_bad = 1'b1;
                    end else begin
                        last_level_next = level;
                        if (ones_cnt_reg == STUFF_LIMIT) begin
                            // Stuffed zero is dropped; a one here is a stuff error
                            if (bit_val) end_bad = 1'b1;
                            else         ones_cnt_next = '0;
                        end else begin
                            shreg_next    = {bit_val, shreg_reg[7:1]};
                            bit_cnt_next  = bit_cnt_reg + 1'b1;
                            ones_cnt_next = bit_val ? ones_cnt_reg + 1'b1 : '0;
                            if (bit_cnt_reg == 3'd7) begin
                                if (byte_cnt_reg == BYTE_LIMIT) begin
                                    end_bad = 1'b1;
                                end else begin
                                    byte_done     = 1'b1;
                                    byte_cnt_next = byte_cnt_reg + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (level == LS_SE0) begin
                        if (se0_cnt_reg == 2'd3) end_bad = 1'b1;
                        else                     se0_cnt_next = se0_cnt_reg + 1'b1;
                    end else if (level == LS_J) begin
                        end_ok          = 1'b1;
                        state_next      = ST_IDLE;
                        last_level_next = LS_J;
                    end else begin
                        end_bad = 1'b1;
                    end
                end
                ST_ERR_WAIT: begin
                    // Wait for two consecutive idle bits before re-arming
                    if (level == LS_J) begin
                        if (j_cnt_reg) begin
                            state_next      = ST_IDLE;
                            last_level_next = LS_J;
                            j_cnt_next      = 1'b0;
                        end else begin
                            j_cnt_next = 1'b1;
                        end
                    end else begin
                        j_cnt_next = 1'b0;
                    end
                end
                default: begin
                    state_next      = ST_IDLE;
                    last_level_next = LS_J;
                end
            endcase
            if (end_bad) begin
                state_next = ST_ERR_WAIT;
                j_cnt_next = 1'b0;
            end
        end
    end

    // Registered strobes; a partial trailing byte marks the packet bad
    always_comb begin
        pkt_start_next = sync_ok;
        pkt_end_next   = end_ok || end_bad || abort;
        pkt_err_next   = end_bad || abort || (end_ok && (bit_cnt_reg != 3'd0));
        rbyte_wr_next  = byte_done;
        rbyte_next     = byte_done ? shreg_next : rbyte_reg;
    end

    assign pkt.rbyte     = rbyte_reg;
    assign pkt.rbyte_wr  = rbyte_wr_reg;
    assign pkt.pkt_start = pkt_start_reg;
    assign pkt.pkt_end   = pkt_end_reg;
    assign pkt.pkt_err   = pkt_err_reg;
    assign pkt.rx_active = (state_reg == ST_DATA) || (state_reg == ST_EOP) || pkt_end_reg;

endmodule

// File: tb/tb_usb11_recv.sv
// Directed bench for usb11_recv: a bus model drives NRZI/stuffed LS packets
// and a monitor collects strobes; expected bytes and flags are hand-derived.
module tb_usb11_recv;
    import usb11_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dp  = 1'b0;
    logic       dm  = 1'b1;
    logic       bus_enable = 1'b0;
    logic [1:0] line_state;

    usb11_recv_if pkt();

    usb11_recv #(
        .SAMPLE_PHASE   (4),
        .SYNC_MIN_ZEROS (5),
        .MAX_BYTES      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dp         (dp),
        .dm         (dm),
        .bus_enable (bus_enable),
        .line_state (line_state),
        .pkt        (pkt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples 2 ns after the rising edge) ----------
    int         n_start = 0, n_end = 0, n_err_end = 0, act_bad = 0, clash = 0;
    bit         in_pkt_m = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        #2;
        if (rst) begin
            in_pkt_m = 1'b0;
        end else begin
            if (pkt.pkt_start) begin
                in_pkt_m = 1'b1;
                n_start++;
                $display("  t=%0t pkt_start", $time);
            end
            if (pkt.rx_active !== in_pkt_m) act_bad++;
            if (pkt.rbyte_wr) begin
                got_q.push_back(pkt.rbyte);
                $display("  t=%0t rbyte_wr rbyte=0x%02h", $time, pkt.rbyte);
            end
            if (pkt.rbyte_wr && pkt.pkt_end) clash++;
            if (pkt.pkt_end) begin
                n_end++;
                if (pkt.pkt_err) n_err_end++;
                in_pkt_m = 1'b0;
                $display("  t=%0t pkt_end err=%0d", $time, pkt.pkt_err);
            end
        end
    end

    // ---------------- bus model ---------------------------------------------
    logic [1:0] cur_lvl = LS_J;
    int         ones = 0;
    int         mode = 0;   // 0: 8 clk, 1: 7/9 alternating, 2: 8.4 average
    int         acc  = 0;
    bit         alt  = 1'b0;

    task automatic hold(input logic [1:0] lvl, input int n);
        {dp, dm} = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_time(input logic [1:0] lvl);
        int p;
        case (mode)
            0: p = 8;
            1: begin p = alt ? 9 : 7; alt = !alt; end
            default: begin
                acc += 4;
                if (acc >= 10) begin acc -= 10; p = 9; end
                else p = 8;
            end
        endcase
        hold(lvl, p);
    endtask

    task automatic send_raw_bit(input bit b);
        if (!b) cur_lvl = (cur_lvl == LS_J) ? LS_K : LS_J;
        bit_time(cur_lvl);
    endtask

    task automatic send_bit(input bit b);
        send_raw_bit(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                send_raw_bit(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_sync();
        cur_lvl = LS_J;
        for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
        send_raw_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop();
        bit_time(LS_SE0);
        bit_time(LS_SE0);
        bit_time(LS_J);
        cur_lvl = LS_J;
    endtask

    // ---------------- per-packet bookkeeping ---------------------------------
    int         s0, e0, r0;
    logic [7:0] exp_q[$];

    task automatic begin_pkt();
        s0 = n_start;
        e0 = n_end;
        r0 = n_err_end;
        got_q.delete();
    endtask

    task automatic expect_pkt(input string tag, input int exp_err);
        logic [31:0] g;
        $display("packet %s: starts=%0d ends=%0d errs=%0d bytes=%0d",
                 tag, n_start - s0, n_end - e0, n_err_end - r0, got_q.size());
        check_val({tag, ".starts"}, n_start - s0, 1);
        check_val({tag, ".ends"}, n_end - e0, 1);
        check_val({tag, ".err"}, n_err_end - r0, exp_err);
        check_val({tag, ".nbytes"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hxxxx_xxxx;
            check_val($sformatf("%s.byte%0d", tag, i), g, {24'h0, exp_q[i]});
        end
    endtask

    task automatic send_ack_and_check(input string tag);
        begin_pkt();
        send_sync();
        send_byte(PID_ACK);
        send_eop();
        hold(LS_J, 40);
        exp_q = '{PID_ACK};
        expect_pkt(tag, 0);
    endtask

    // ---------------- watchdog ----------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        hold(LS_J, 4);
        @(posedge clk); #2;
        check_val("rst.rbyte", pkt.rbyte, 8'h00);
        check_val("rst.rbyte_wr", pkt.rbyte_wr, 1'b0);
        check_val("rst.pkt_start", pkt.pkt_start, 1'b0);
        check_val("rst.pkt_end", pkt.pkt_end, 1'b0);
        check_val("rst.pkt_err", pkt.pkt_err, 1'b0);
        check_val("rst.rx_active", pkt.rx_active, 1'b0);
        check_val("rst.line_state", line_state, LS_J);
        @(negedge clk);
        rst = 1'b0;
        hold(LS_J, 40);

        // Handshake ACK
        send_ack_and_check("ack");

        // Data with stuffing inside the FF run
        begin_pkt();
        send_sync();
        send_byte(8'hC3); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        send_eop();
        hold(LS_J, 40);
        exp_q = '{8'hC3, 8'hFF, 8'hFF, 8'h00};
        expect_pkt("data4", 0);

        // Unstuffed run of ones: stuff error, then recovery
        begin_pkt();
        send_sync();
        for (int i = 0; i < 16; i++) send_raw_bit(1'b1);
        send_eop();
        hold(LS_J, 40);
        exp_q.delete();
        expect_pkt("stufferr", 1);
        send_ack_and_check("ack_after_err");

        // One byte plus four bits: partial byte dropped, packet bad
        begin_pkt();
        send_sync();
        send_byte(PID_ACK);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_eop();
        hold(LS_J, 40);
        exp_q = '{PID_ACK};
        expect_pkt("partial", 1);

        // Jittered bit periods
        mode = 1; alt = 1'b0;
        begin_pkt();
        send_sync();
        send_byte(PID_NAK);
        send_eop();
        hold(LS_J, 40);
        exp_q = '{PID_NAK};
        expect_pkt("nak_7_9", 0);

        mode = 2; acc = 0;
        begin_pkt();
        send_sync();
        send_byte(PID_NAK);
        send_eop();
        hold(LS_J, 40);
        exp_q = '{PID_NAK};
        expect_pkt("nak_8p4", 0);
        mode = 0;

        // bus_enable abort mid-DATA
        begin_pkt();
        send_sync();
        send_byte(PID_ACK);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_enable = 1'b1;
        cur_lvl = LS_J;
        hold(LS_J, 20);
        bus_enable = 1'b0;
        hold(LS_J, 40);
        exp_q = '{PID_ACK};
        expect_pkt("bus_enable", 1);

        // One-clock reset mid-packet
        begin_pkt();
        send_sync();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        rst = 1'b1;
        {dp, dm} = LS_J;
        cur_lvl = LS_J;
        @(posedge clk); #2;
        check_val("midrst.rbyte", pkt.rbyte, 8'h00);
        check_val("midrst.rbyte_wr", pkt.rbyte_wr, 1'b0);
        check_val("midrst.pkt_end", pkt.pkt_end, 1'b0);
        check_val("midrst.pkt_err", pkt.pkt_err, 1'b0);
        check_val("midrst.rx_active", pkt.rx_active, 1'b0);
        check_val("midrst.line_state", line_state, LS_J);
        @(negedge clk);
        rst = 1'b0;
        hold(LS_J, 40);
        $display("packet midrst: starts=%0d ends=%0d", n_start - s0, n_end - e0);
        check_val("midrst.starts", n_start - s0, 1);
        check_val("midrst.ends", n_end - e0, 0);
        send_ack_and_check("ack_after_rst");

        check_val("rx_active_span", act_bad, 0);
        check_val("wr_end_overlap", clash, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/usb11_recv.md
Name: usb11_recv

Overview:
Low-speed (1.5 Mbit/s) USB receiver. It takes the raw dp/dm bus lines, recovers bit timing by 8x oversampling at 12 MHz, and NRZI-decodes the bit stream. It detects SYNC, removes stuffed bits, assembles bytes LSB-first and detects EOP. It is the receive-side companion of the LS transmitter on the same bus: it delivers response packets (handshake/data) byte by byte to the packet layer, with start, end and error strobes.

Parameters:
SAMPLE_PHASE, 4, phase-counter value (0..7) at which the line is sampled; mid-bit.
SYNC_MIN_ZEROS, 5, minimum decoded zeros before the terminating SYNC one (tolerates hub-dropped SYNC bits).
MAX_BYTES, 16, byte count above which the packet is aborted as babble.

Ports:
clk  input  1  12 MHz system clock
rst  input  1  synchronous, active-high reset
dp  input  1  USB D+ line, asynchronous to clk
dm  input  1  USB D- line, asynchronous to clk
bus_enable  input  1  local transmitter drives the bus; receiver held idle
rbyte  output  8  received byte, valid while rbyte_wr=1
rbyte_wr  output  1  one-clk strobe, new byte in rbyte
pkt_start  output  1  one-clk strobe, SYNC accepted
pkt_end  output  1  one-clk strobe, packet finished (good or bad)
pkt_err  output  1  qualifies pkt_end: packet bad
rx_active  output  1  high from pkt_start up to and including the pkt_end cycle
line_state  output  2  synchronized {dp,dm}, for attach/disconnect monitoring

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst). On reset: state IDLE, all strobes 0, rbyte=0, rx_active=0, line_state=2'b01 (J).
- Line states (LS): J={dp,dm}=01, K=10, SE0=00, SE1=11 (SE1 treated as error in DATA).
- Input path: 2-flop synchronizer on dp/dm, then a one-stage "previous" register. line_state is the second-stage flop output.
- Timing recovery: 3-bit phase counter.
  - Cleared to 0 on any clk where synced state != previous synced state; otherwise increments and wraps 7->0.
  - Sample strobe fires when counter==SAMPLE_PHASE.
  - One sample per bit time, re-aligned on every transition.
- NRZI decode on each sample: bit=1 if sampled level equals last sampled level, else 0. The last level is initialised to J in IDLE.
- FSM states and transitions:
  - IDLE: on sample==K go to SYNC, zero_cnt=1.
  - SYNC:
    - decoded 0: zero_cnt++ (saturating).
    - decoded 1 with zero_cnt>=SYNC_MIN_ZEROS: go to DATA, pulse pkt_start, rx_active=1; clear bit_cnt, ones_cnt, byte_cnt.
    - decoded 1 with too few zeros, or SE0: back to IDLE, no strobes.
  - DATA, on each sample:
    - SE0: go to EOP.
    - SE1: error.
    - ones_cnt==6: the bit is a stuff bit. A decoded 0 is discarded and clears ones_cnt; a decoded 1 is a stuff error.
    - Otherwise: shift the bit into shreg[7] (right shift, LSB first), bit_cnt++, ones_cnt=bit?ones_cnt+1:0.
    - When bit_cnt wraps 7->0: rbyte<=assembled byte and rbyte_wr=1 on the next clk (latency: 1 clk after the 8th data-bit sample), byte_cnt++.
    - byte_cnt>MAX_BYTES: error.
  - EOP: next sample SE0 stays in EOP (max 3 samples, then error); next sample J ends the packet.
    - pkt_end=1, pkt_err=(bit_cnt!=0), i.e. a partial trailing byte is discarded and not written.
    - Then go to IDLE.
    - Next sample K is an error.
  - ERR_WAIT: reached on any error, with a same-clk pulse of pkt_end=1 and pkt_err=1. Leaves to IDLE after 2 consecutive J samples. No rbyte_wr in this state.
- bus_enable=1: FSM forced to IDLE on the next clk. If it was in DATA or EOP, pulse pkt_end with pkt_err=1 once. Strobes are otherwise suppressed.
- Exactly one pkt_end per pkt_start. rbyte_wr never coincides with pkt_end.
- rst mid-packet: immediate return to IDLE; no pkt_end is issued.

Decomposition:
- Shared package usb11_pkg holds:
  - line-state constants J/K/SE0/SE1
  - FSM state encodings (IDLE, SYNC, DATA, EOP, ERR_WAIT)
  - LS oversample ratio (8)
  - stuff limit (6)
  - the PID constants already used by the packet layer
- One sub-module, usb11_rx_dpll: synchronizer, previous-state register, phase counter and sample strobe. Its outputs are line_state, sample_en and sampled level.

Test Plan:
- Bus model, 8 clk/bit: SYNC + PID 0xD2 (ACK) + EOP (2xSE0, J) -> pkt_start; one rbyte_wr with rbyte=0xD2; pkt_end with pkt_err=0; rx_active spans start..end.
- SYNC + bytes 0xC3,0xFF,0xFF,0x00 + EOP (stuff bits inserted by model) -> four rbyte_wr with rbyte=0xC3,0xFF,0xFF,0x00 exactly; pkt_err=0.
- Seven identical consecutive levels (unstuffed 0xFF 0xFF) -> pkt_end with pkt_err=1; no further rbyte_wr; IDLE after 2 J bits; the next clean ACK is received.
- SYNC + 12 data bits + EOP -> one rbyte_wr (first byte); pkt_end with pkt_err=1; partial byte not written.
- Bit period 7 then 9 clk alternating, and a constant 8.4-clk period, with PID 0x5A -> received correctly, pkt_err=0.
- Two aborts: bus_enable raised mid-DATA -> single pkt_end with pkt_err=1. rst asserted for 1 clk mid-packet -> no pkt_end, all outputs at reset values, the next packet is received.
